traffic_light_monitor: RTL

Passive conflict monitor that observes the 3-bit one-hot light bus driven by the traffic light controller. It checks every colour change for a legal sequence and every colour segment for the correct dwell time. Violations raise a latched fault with a code. It also counts completed RED→GREEN→YELLOW→RED periods. It sits beside the controller and feeds the supervisor / fail-safe flasher logic.

---
 rtl/traffic_light_monitor.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/traffic_light_monitor.sv
// Passive monitor for a one-hot traffic light bus. It checks colour order and
// segment dwell times, latches the first fault code, and counts full R-G-Y periods.
module traffic_light_monitor #(
  parameter int RED_DWELL    = 11,
  parameter int GREEN_DWELL  = 11,
  parameter int YELLOW_DWELL = 6,
  parameter int TOL          = 1,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       light_in,
  input  logic             enable,
  input  logic             clear_fault,
  output logic             fault,
  output logic [2:0]       fault_code,
  output logic             seg_done,
  output logic [CNT_W-1:0] period_count,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    RUN   = 2'd2,
    FAULT = 2'd3
  } state_e;

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] GREEN  = 3'b001;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [CNT_W-1:0] DWELL_MAX = '1;

  // The stuck check needs DWELL+TOL to be reachable below the saturation value.
  if ((RED_DWELL + TOL >= (1 << CNT_W) - 1) ||
      (GREEN_DWELL + TOL >= (1 << CNT_W) - 1) ||
      (YELLOW_DWELL + TOL >= (1 << CNT_W) - 1)) begin : g_width_check
    $error("traffic_light_monitor: DWELL+TOL does not fit below 2^CNT_W-1");
  end

  state_e           state_q, state_d;
  logic [2:0]       s_light_q;
  logic [2:0]       prev_q, prev_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic             fault_q, fault_d;
  logic [2:0]       code_q, code_d;
  logic             seg_done_q, seg_done_d;
  logic [CNT_W-1:0] period_q, period_d;

  logic       valid;
  logic       boundary;
  logic [2:0] legal_next;
  int         exp_dwell;
  int         dwell_i;
  logic [2:0] viol;

  always_comb begin
    valid      = (s_light_q == RED) || (s_light_q == GREEN) || (s_light_q == YELLOW);
    boundary   = (s_light_q != prev_q);
    dwell_i    = int'(dwell_q);
    exp_dwell  = YELLOW_DWELL;
    legal_next = RED;
    case (prev_q)
      RED:     begin exp_dwell = RED_DWELL;   legal_next = GREEN;  end
      GREEN:   begin exp_dwell = GREEN_DWELL; legal_next = YELLOW; end
      default: begin exp_dwell = YELLOW_DWELL; legal_next = RED;   end
    endcase

    viol = 3'd0;
    if (!valid)                                                     viol = 3'd1;
    else if (boundary && (s_light_q != legal_next))                 viol = 3'd2;
    else if (boundary && (state_q == RUN) && (dwell_i < exp_dwell - TOL)) viol = 3'd3;
    else if (!boundary && (dwell_i >= exp_dwell + TOL))             viol = 3'd4;

    dwell_d = boundary ? CNT_W'(1) : ((dwell_q == DWELL_MAX) ? dwell_q : dwell_q + CNT_W'(1));

    state_d    = state_q;
    prev_d     = prev_q;
    fault_d    = fault_q;
    code_d     = code_q;
    seg_done_d = 1'b0;
    period_d   = period_q;

    // While not checking, the segment colour follows any valid sample so that
    // re-arming starts from the real current colour.
    case (state_q)
      IDLE: begin
        if (valid) prev_d = s_light_q;
        if (enable) state_d = SYNC;
      end
      SYNC, RUN: begin
        if (!enable) begin
          if (valid) prev_d = s_light_q;
          state_d = IDLE;
        end else if (viol != 3'd0) begin
          state_d = FAULT;
          fault_d = 1'b1;
          code_d  = viol;
        end else if (boundary) begin
          seg_done_d = 1'b1;
          prev_d     = s_light_q;
          state_d    = RUN;
          if ((state_q == RUN) && (prev_q == YELLOW)) period_d = period_q + CNT_W'(1);
        end
      end
      default: begin
        if (valid) prev_d = s_light_q;
        if (clear_fault) begin
          state_d = enable ? SYNC : IDLE;
          fault_d = 1'b0;
          code_d  = 3'd0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      s_light_q  <= RED;
      prev_q     <= RED;
      dwell_q    <= '0;
      fault_q    <= 1'b0;
      code_q     <= 3'd0;
      seg_done_q <= 1'b0;
      period_q   <= '0;
    end else begin
      state_q    <= state_d;
      s_light_q  <= light_in;
      prev_q     <= prev_d;
      dwell_q    <= dwell_d;
      fault_q    <= fault_d;
      code_q     <= code_d;
      seg_done_q <= seg_done_d;
      period_q   <= period_d;
    end
  end

  assign fault        = fault_q;
  assign fault_code   = code_q;
  assign seg_done     = seg_done_q;
  assign period_count = period_q;
  assign state_dbg    = state_q;

endmodule
